// File: rtl/touch_panel_adc_spi.sv
// Avalon-MM slave that sends an 8-bit command to the touch-panel ADC and reads back the conversion result.
// Optional pen-down auto trigger is enabled with `define TOUCH_PANEL_AUTO_TRIGGER_EN.
module touch_panel_adc_spi #(
  parameter int CLK_DIV  = 25,
  parameter int RESULT_W = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        spi_cs_n,
  output logic        spi_dclk,
  output logic        spi_din,
  input  logic        spi_dout,
  input  logic        pen_irq_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic              phase_q, phase_d;
  logic [15:0]       rx_q, rx_d;
  logic              cs_n_q, cs_n_d;
  logic              dclk_q, dclk_d;
  logic              din_q, din_d;
  logic              busy_q, busy_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic              irq_mask_q, irq_mask_d;
  logic              done_q, done_d;
  logic [15:0]       readdata_q, readdata_d;

  logic              wr;
  logic              sw_start;
  logic              auto_start;
  logic              start;
  logic [7:0]        start_cmd;
  logic              div_last;
  logic [DIV_W-1:0]  div_inc;
  logic [4:0]        bit_nx;
  logic              auto_en_rd;
  logic              unused_bits;

`ifdef TOUCH_PANEL_AUTO_TRIGGER_EN
  logic              auto_en_q, auto_en_d;
  logic [1:0]        pen_sync_q, pen_sync_d;

  always_comb begin
    auto_en_d  = auto_en_q;
    pen_sync_d = {pen_sync_q[0], pen_irq_n};
    if (wr && address == 2'd2) begin
      auto_en_d = writedata[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_en_q  <= 1'b0;
      pen_sync_q <= 2'b11;
    end else begin
      auto_en_q  <= auto_en_d;
      pen_sync_q <= pen_sync_d;
    end
  end

  // Gating on done stops a held-down pen from retriggering until software acknowledges.
  assign auto_start = auto_en_q && (state_q == S_IDLE) && !done_q && !pen_sync_q[1];
  assign auto_en_rd = auto_en_q;
`else
  assign auto_start = 1'b0;
  assign auto_en_rd = 1'b0;
`endif

  assign wr        = chipselect & ~write_n;
  assign sw_start  = wr && (address == 2'd0) && !busy_q;
  assign start     = sw_start | auto_start;
  assign start_cmd = sw_start ? writedata[7:0] : cmd_q;
  assign div_last  = (div_q == DIV_LAST);
  assign div_inc   = div_q + DIV_W'(1);
  assign bit_nx    = bit_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    rx_d       = rx_q;
    cs_n_d     = cs_n_q;
    dclk_d     = dclk_q;
    din_d      = din_q;
    busy_d     = busy_q;
    cmd_d      = start ? start_cmd : cmd_q;
    result_d   = result_q;
    irq_mask_d = irq_mask_q;
    done_d     = done_q;

    if (wr && address == 2'd2) begin
      irq_mask_d = writedata[0];
    end
    // Clear first so that a set from S_DONE in the same cycle takes priority.
    if (wr && address == 2'd3) begin
      done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          dclk_d  = 1'b0;
          din_d   = start_cmd[7];
          div_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = 5'd0;
          phase_d = 1'b0;
        end else begin
          div_d = div_inc;
        end
      end
      S_SHIFT: begin
        if (!div_last) begin
          div_d = div_inc;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // Sample on the edge that raises dclk; the ADC shifts out on the falling edge.
            phase_d = 1'b1;
            dclk_d  = 1'b1;
            if (bit_q >= 5'd8) begin
              rx_d = {rx_q[14:0], spi_dout};
            end
          end else if (bit_q == LAST_BIT) begin
            state_d = S_HOLD;
            phase_d = 1'b0;
            dclk_d  = 1'b0;
            din_d   = 1'b0;
          end else begin
            bit_d   = bit_nx;
            phase_d = 1'b0;
            dclk_d  = 1'b0;
            din_d   = (bit_nx < 5'd8) ? cmd_q[3'd7 - bit_nx[2:0]] : 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (div_last) begin
          state_d = S_DONE;
          cs_n_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_inc;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = rx_q[14 -: RESULT_W];
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        dclk_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      2'd0: readdata_d = {busy_q, 7'b0, cmd_q};
      2'd1: readdata_d = 16'(result_q);
      2'd2: readdata_d = {14'b0, auto_en_rd, irq_mask_q};
      2'd3: readdata_d = {15'b0, done_q};
      default: readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= 5'd0;
      phase_q    <= 1'b0;
      rx_q       <= 16'h0000;
      cs_n_q     <= 1'b1;
      dclk_q     <= 1'b0;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      cmd_q      <= 8'h00;
      result_q   <= '0;
      irq_mask_q <= 1'b0;
      done_q     <= 1'b0;
      readdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      rx_q       <= rx_d;
      cs_n_q     <= cs_n_d;
      dclk_q     <= dclk_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      cmd_q      <= cmd_d;
      result_q   <= result_d;
      irq_mask_q <= irq_mask_d;
      done_q     <= done_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign irq         = done_q & irq_mask_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_dclk    = dclk_q;
  assign spi_din     = din_q;
  assign unused_bits = ^{pen_irq_n, writedata[15:8], rx_q};

endmodule

// File: tb/tb_touch_panel_adc_spi.sv
// Self-checking bench for touch_panel_adc_spi: randomized commands/ADC frames against a frame-level reference model.
module tb_touch_panel_adc_spi;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;
  logic        spi_cs_n;
  logic        spi_dclk;
  logic        spi_din;
  logic        spi_dout = 1'b0;
  logic        pen_irq_n = 1'b1;

  int total = 0;
  int bad = 0;

  // ADC model / bus monitor state
  logic [15:0] adc_frame = 16'h0000;
  int          pulse_cnt = 0;
  int          cs_low_cyc = 0;
  int          din_hi_late = 0;
  logic [7:0]  din_bits = 8'h00;
  logic [11:0] last_result = 12'h000;

  touch_panel_adc_spi #(.CLK_DIV(N), .RESULT_W(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .spi_cs_n   (spi_cs_n),
    .spi_dclk   (spi_dclk),
    .spi_din    (spi_din),
    .spi_dout   (spi_dout),
    .pen_irq_n  (pen_irq_n)
  );

  always #5 clk = ~clk;

  // ADC model: captures din on each dclk rise, presents the next result bit after each dclk fall.
  initial begin
    logic prev_dclk;
    logic prev_cs_n;
    prev_dclk = 1'b0;
    prev_cs_n = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_cs_n === 1'b1 && spi_cs_n === 1'b0) begin
        pulse_cnt   = 0;
        cs_low_cyc  = 0;
        din_hi_late = 0;
        din_bits    = 8'h00;
      end
      if (spi_cs_n === 1'b0) cs_low_cyc++;
      if (spi_dclk === 1'b1 && prev_dclk === 1'b0) begin
        if (pulse_cnt < 8) din_bits[7 - pulse_cnt] = spi_din;
        else if (spi_din !== 1'b0) din_hi_late++;
        pulse_cnt++;
      end
      if ((spi_dclk === 1'b0 && prev_dclk === 1'b1) || (prev_cs_n === 1'b1 && spi_cs_n === 1'b0)) begin
        if (pulse_cnt >= 8 && pulse_cnt < 24) spi_dout = adc_frame[23 - pulse_cnt];
        else spi_dout = 1'($urandom_range(0, 1));
      end
      prev_dclk = spi_dclk;
      prev_cs_n = spi_cs_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] model_result(input logic [15:0] frame);
    return 12'((frame >> 3) & 16'h0FFF);
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // Returns at the negedge where cs_n is first seen high again.
  task automatic wait_cs_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 * N; i++) begin
      if (spi_cs_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_txn(input logic [7:0] cmd, input logic [15:0] frame, output bit ok);
    adc_frame = frame;
    bus_write(2'd0, {8'($urandom_range(0, 255)), cmd});
    wait_cs_high(ok);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
    total++; if (spi_dclk !== 1'b0) begin bad++; $display("FAIL reset_dclk: got %b want 0", spi_dclk); end
    total++; if (spi_din !== 1'b0) begin bad++; $display("FAIL reset_din: got %b want 0", spi_din); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (readdata !== 16'h0000) begin bad++; $display("FAIL reset_readdata: got %h want 0000", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_reg%0d: got %h want 0000", a, rd); end
    end
  endtask

  task automatic test_basic();
    logic [15:0] rd;
    bit ok;
    bus_write(2'd2, 16'h0001);
    adc_frame = 16'h52E0;
    bus_write(2'd0, 16'h0093);
    total++; if (spi_cs_n !== 1'b0) begin bad++; $display("FAIL basic_cs_fall: got %b want 0", spi_cs_n); end
    wait_cs_high(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no cs_n rise want rise"); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_at_cs_rise: got %b want 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq_after_done: got %b want 1", irq); end
    total++; if (cs_low_cyc != 50 * N) begin bad++; $display("FAIL basic_cs_low: got %0d want %0d", cs_low_cyc, 50 * N); end
    total++; if (pulse_cnt != 24) begin bad++; $display("FAIL basic_pulses: got %0d want 24", pulse_cnt); end
    total++; if (din_bits !== 8'h93) begin bad++; $display("FAIL basic_din: got %h want 93", din_bits); end
    total++; if (din_hi_late != 0) begin bad++; $display("FAIL basic_din_tail: got %0d ones want 0", din_hi_late); end
    bus_read(2'd1, rd);
    total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL basic_result: got %h want 0a5c", rd); end
    bus_read(2'd3, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL basic_done: got %h want 0001", rd); end
    bus_read(2'd0, rd);
    total++; if (rd !== 16'h0093) begin bad++; $display("FAIL basic_cmd: got %h want 0093", rd); end
    last_result = 12'hA5C;
  endtask

  task automatic test_irq();
    logic [15:0] rd;
    logic [15:0] fr;
    bit ok;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_pending: got %b want 1", irq); end
    bus_write(2'd3, 16'h0000);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_write(2'd2, 16'h0000);
    fr = 16'($urandom);
    do_txn(8'($urandom), fr, ok);
    total++; if (!ok) begin bad++; $display("FAIL irq_timeout: got no cs_n rise want rise"); end
    last_result = model_result(fr);
    bus_read(2'd3, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL irq_done_masked: got %h want 0001", rd); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq); end
    end
    bus_write(2'd2, 16'h0001);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_unmask: got %b want 1", irq); end
    bus_write(2'd3, 16'h0000);
    bus_write(2'd2, 16'h0000);
  endtask

  task automatic test_busy();
    logic [15:0] rd;
    logic [15:0] fr;
    bit ok;
    fr = 16'($urandom);
    adc_frame = fr;
    bus_write(2'd0, 16'h0093);
    repeat (20) @(negedge clk);
    bus_write(2'd0, 16'h00D3);
    bus_read(2'd0, rd);
    total++; if (rd !== 16'h8093) begin bad++; $display("FAIL busy_cmd: got %h want 8093", rd); end
    bus_read(2'd1, rd);
    total++; if (rd !== {4'h0, last_result}) begin bad++; $display("FAIL busy_result_held: got %h want %h", rd, {4'h0, last_result}); end
    wait_cs_high(ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no cs_n rise want rise"); end
    @(negedge clk);
    total++; if (pulse_cnt != 24) begin bad++; $display("FAIL busy_pulses: got %0d want 24", pulse_cnt); end
    total++; if (din_bits !== 8'h93) begin bad++; $display("FAIL busy_din: got %h want 93", din_bits); end
    last_result = model_result(fr);
    bus_read(2'd1, rd);
    total++; if (rd !== {4'h0, last_result}) begin bad++; $display("FAIL busy_result: got %h want %h", rd, {4'h0, last_result}); end
    bus_read(2'd0, rd);
    total++; if (rd !== 16'h0093) begin bad++; $display("FAIL busy_idle_cmd: got %h want 0093", rd); end
    begin
      int low = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (spi_cs_n !== 1'b1) low++;
      end
      total++; if (low != 0) begin bad++; $display("FAIL busy_second_txn: got %0d low cycles want 0", low); end
    end
    bus_write(2'd3, 16'h0000);
  endtask

  task automatic test_collision();
    logic [15:0] rd;
    logic [15:0] fr;
    bit ok;
    bus_read(2'd3, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL coll_pre_done: got %h want 0000", rd); end
    fr = 16'($urandom);
    adc_frame = fr;
    bus_write(2'd0, {8'h00, 8'($urandom)});
    wait_cs_high(ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_timeout: got no cs_n rise want rise"); end
    address = 2'd3; writedata = 16'hFFFF; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    last_result = model_result(fr);
    bus_read(2'd3, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL coll_done: got %h want 0001", rd); end
    bus_write(2'd3, 16'h0000);
  endtask

  task automatic test_start_in_done();
    logic [15:0] rd;
    logic [15:0] fr;
    logic [7:0]  c1;
    bit ok;
    int low;
    c1 = 8'($urandom);
    fr = 16'($urandom);
    adc_frame = fr;
    bus_write(2'd0, {8'h00, c1});
    wait_cs_high(ok);
    total++; if (!ok) begin bad++; $display("FAIL sid_timeout: got no cs_n rise want rise"); end
    address = 2'd0; writedata = {8'h00, ~c1}; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    last_result = model_result(fr);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1) low++;
    end
    total++; if (low != 0) begin bad++; $display("FAIL sid_no_restart: got %0d low cycles want 0", low); end
    bus_read(2'd0, rd);
    total++; if (rd !== {8'h00, c1}) begin bad++; $display("FAIL sid_cmd: got %h want %h", rd, {8'h00, c1}); end
    bus_write(2'd3, 16'h0000);
  endtask

  task automatic test_regs();
    logic [15:0] rd;
    logic [15:0] exp_mask;
`ifdef TOUCH_PANEL_AUTO_TRIGGER_EN
    exp_mask = 16'h0003;
`else
    exp_mask = 16'h0001;
`endif
    bus_write(2'd2, 16'hFFFF);
    bus_read(2'd2, rd);
    total++; if (rd !== exp_mask) begin bad++; $display("FAIL regs_mask: got %h want %h", rd, exp_mask); end
    bus_write(2'd2, 16'h0000);
    bus_write(2'd1, 16'hFFFF);
    bus_read(2'd1, rd);
    total++; if (rd !== {4'h0, last_result}) begin bad++; $display("FAIL regs_result_ro: got %h want %h", rd, {4'h0, last_result}); end
  endtask

  task automatic test_random();
    logic [15:0] rd;
    logic [15:0] fr;
    logic [7:0]  c;
    bit ok;
    for (int t = 0; t < 6; t++) begin
      c  = 8'($urandom);
      fr = 16'($urandom);
      do_txn(c, fr, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout: got no cs_n rise want rise", t); end
      total++; if (din_bits !== c) begin bad++; $display("FAIL rand%0d_din: got %h want %h", t, din_bits, c); end
      total++; if (cs_low_cyc != 50 * N) begin bad++; $display("FAIL rand%0d_cs_low: got %0d want %0d", t, cs_low_cyc, 50 * N); end
      total++; if (pulse_cnt != 24) begin bad++; $display("FAIL rand%0d_pulses: got %0d want 24", t, pulse_cnt); end
      total++; if (din_hi_late != 0) begin bad++; $display("FAIL rand%0d_din_tail: got %0d ones want 0", t, din_hi_late); end
      last_result = model_result(fr);
      bus_read(2'd1, rd);
      total++; if (rd !== {4'h0, last_result}) begin bad++; $display("FAIL rand%0d_result: got %h want %h", t, rd, {4'h0, last_result}); end
      bus_write(2'd3, 16'h0000);
    end
  endtask

`ifdef TOUCH_PANEL_AUTO_TRIGGER_EN
  task automatic test_auto();
    bit ok;
    int dly;
    int low;
    do_txn(8'h93, 16'h1234, ok);
    bus_write(2'd3, 16'h0000);
    bus_write(2'd2, 16'h0002);
    adc_frame = 16'($urandom);
    @(negedge clk);
    pen_irq_n = 1'b0;
    dly = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b0) begin dly = i; break; end
    end
    total++; if (dly < 3 || dly > 4) begin bad++; $display("FAIL auto_start_delay: got %0d want 3..4", dly); end
    wait_cs_high(ok);
    total++; if (!ok) begin bad++; $display("FAIL auto_timeout: got no cs_n rise want rise"); end
    @(negedge clk);
    total++; if (din_bits !== 8'h93) begin bad++; $display("FAIL auto_din: got %h want 93", din_bits); end
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1) low++;
    end
    total++; if (low != 0) begin bad++; $display("FAIL auto_retrigger: got %0d low cycles want 0", low); end
    bus_write(2'd3, 16'h0000);
    @(negedge clk);
    total++; if (spi_cs_n !== 1'b0) begin bad++; $display("FAIL auto_rearm: got %b want 0", spi_cs_n); end
    pen_irq_n = 1'b1;
    bus_write(2'd2, 16'h0000);
    wait_cs_high(ok);
    @(negedge clk);
    last_result = model_result(adc_frame);
    bus_write(2'd3, 16'h0000);
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] rd;
    bit ok;
    bit hit;
    do_txn(8'hA7, 16'h52E0, ok);
    bus_write(2'd3, 16'h0000);
    adc_frame = 16'($urandom);
    bus_write(2'd0, 16'h00C5);
    hit = 1'b0;
    for (int i = 0; i < 200 * N; i++) begin
      @(negedge clk);
      if (pulse_cnt >= 11) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach_bit: got %0d pulses want >=11", pulse_cnt); end
    total++; if (spi_cs_n !== 1'b0) begin bad++; $display("FAIL rmid_pre_cs: got %b want 0", spi_cs_n); end
    reset_n = 1'b0;
    #1;
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rmid_cs_n: got %b want 1", spi_cs_n); end
    total++; if (spi_dclk !== 1'b0) begin bad++; $display("FAIL rmid_dclk: got %b want 0", spi_dclk); end
    total++; if (spi_din !== 1'b0) begin bad++; $display("FAIL rmid_din: got %b want 0", spi_din); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rmid_result: got %h want 0000", rd); end
    bus_read(2'd3, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rmid_done: got %h want 0000", rd); end
    bus_read(2'd0, rd);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rmid_cmd: got %h want 0000", rd); end
    repeat (10) @(negedge clk);
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rmid_idle: got %b want 1", spi_cs_n); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_irq();
    test_busy();
    test_collision();
    test_start_in_done();
    test_regs();
    test_random();
`ifdef TOUCH_PANEL_AUTO_TRIGGER_EN
    test_auto();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
